// File: rtl/fc_input_cond.sv
// Input conditioner for the frequency-counter core: synchroniser, glitch filter,
// edge detect, /1 /10 /100 prescaler and activity monitor. Filter enabled by FC_COND_GLITCH_FILTER_EN.
module fc_input_cond #(
   parameter int FILT_LEN = 4,
   parameter int TIMEOUT  = 50000000,
   parameter int IDLE_W   = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig_in,
   input  logic [1:0] range,
   output logic       out,
   output logic       edge_pulse,
   output logic       alive
);

`ifdef FC_COND_GLITCH_FILTER_EN
   localparam bit FILT_EN = 1'b1;
`else
   localparam bit FILT_EN = 1'b0;
`endif

   // A terminal count of zero makes the filter accept s2 on the first differing cycle,
   // which is exactly a direct f <= s2 path.
   localparam logic [3:0]        FILT_TERM = FILT_EN ? 4'(FILT_LEN - 1) : 4'd0;
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

   logic              s1, s2, f, f_d;
   logic [3:0]        fcnt;
   logic [1:0]        range_q;
   logic [5:0]        pcnt;
   logic [IDLE_W-1:0] idle;

   logic              f_nxt, out_nxt, alive_nxt, range_chg;
   logic [3:0]        fcnt_nxt;
   logic [5:0]        pcnt_nxt, pterm;
   logic [IDLE_W-1:0] idle_nxt;

   always_comb begin
      f_nxt     = f;
      fcnt_nxt  = 4'd0;
      out_nxt   = out;
      pcnt_nxt  = pcnt;
      range_chg = (range != range_q);
      pterm     = (range_q == 2'b01) ? 6'd4 : 6'd49;

      if (s2 == f) begin
         fcnt_nxt = 4'd0;
      end else if (fcnt == FILT_TERM) begin
         f_nxt    = s2;
         fcnt_nxt = 4'd0;
      end else begin
         fcnt_nxt = fcnt + 4'd1;
      end

      // A range change wins over a coincident edge, which is then not counted.
      if (range_chg) begin
         out_nxt  = 1'b0;
         pcnt_nxt = 6'd0;
      end else if (range_q == 2'b00) begin
         out_nxt  = f_d;
         pcnt_nxt = 6'd0;
      end else if (edge_pulse) begin
         if (pcnt == pterm) begin
            out_nxt  = ~out;
            pcnt_nxt = 6'd0;
         end else begin
            pcnt_nxt = pcnt + 6'd1;
         end
      end else begin
         pcnt_nxt = pcnt;
      end

      if (edge_pulse) begin
         idle_nxt = '0;
      end else if (idle >= IDLE_MAX) begin
         idle_nxt = IDLE_MAX;
      end else begin
         idle_nxt = idle + 1'b1;
      end
      alive_nxt = (idle_nxt < IDLE_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         f          <= 1'b0;
         f_d        <= 1'b0;
         fcnt       <= 4'd0;
         range_q    <= 2'b00;
         pcnt       <= 6'd0;
         idle       <= IDLE_MAX;
         out        <= 1'b0;
         edge_pulse <= 1'b0;
         alive      <= 1'b0;
      end else begin
         s1         <= sig_in;
         s2         <= s1;
         f          <= f_nxt;
         f_d        <= f;
         fcnt       <= fcnt_nxt;
         range_q    <= range;
         pcnt       <= pcnt_nxt;
         idle       <= idle_nxt;
         out        <= out_nxt;
         edge_pulse <= f & ~f_d;
         alive      <= alive_nxt;
      end
   end

endmodule

// File: tb/tb_fc_input_cond.sv
// Directed self-checking bench for fc_input_cond; expectations follow FC_COND_GLITCH_FILTER_EN.
module tb_fc_input_cond;

   localparam int FILT_LEN = 4;
   localparam int TIMEOUT  = 1000;
   localparam int IDLE_W   = 10;
`ifdef FC_COND_GLITCH_FILTER_EN
   localparam int LAT       = FILT_LEN + 3;
   localparam int GLITCH_EP = 0;
`else
   localparam int LAT       = 4;
   localparam int GLITCH_EP = 3;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       sig_in;
   logic [1:0] range;
   logic       out, edge_pulse, alive;

   int   errors = 0;
   int   checks = 0;
   int   ep_cnt = 0;
   int   tog_cnt = 0;
   logic out_prev = 1'b0;

   fc_input_cond #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .IDLE_W(IDLE_W)) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .range(range),
      .out(out), .edge_pulse(edge_pulse), .alive(alive)
   );

   always #10 clk = ~clk;

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
      if (edge_pulse === 1'b1) ep_cnt++;
      if (out !== out_prev) tog_cnt++;
      out_prev = out;
   endtask

   task automatic do_reset;
      rst = 1'b1; sig_in = 1'b0; range = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      ep_cnt = 0; tog_cnt = 0; out_prev = 1'b0;
   endtask

   task automatic period(input int hi, input int lo);
      sig_in = 1'b1;
      repeat (hi) tick();
      sig_in = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic wait_edge;
      int n;
      n = 0;
      tick();
      while (edge_pulse !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (edge_pulse !== 1'b1) begin
         errors++;
         $display("FAIL wait_edge_timeout: edge_pulse=%b after %0d cycles, required 1", edge_pulse, n);
      end
   endtask

   task automatic test_reset;
      do_reset();
      for (int k = 0; k < 100; k++) begin
         tick();
         checks++;
         if ({out, edge_pulse, alive} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: out/edge_pulse/alive=%b%b%b required 000", k, out, edge_pulse, alive);
         end
      end
   endtask

   task automatic test_latency;
      do_reset();
      sig_in = 1'b1;
      for (int k = 1; k <= LAT + 3; k++) begin
         tick();
         checks++;
         if (edge_pulse !== (k == LAT)) begin
            errors++;
            $display("FAIL latency_edge clk %0d: edge_pulse=%b required %b", k, edge_pulse, (k == LAT));
         end
         checks++;
         if (out !== (k > LAT) || alive !== (k > LAT)) begin
            errors++;
            $display("FAIL latency_out_alive clk %0d: out=%b alive=%b required %b", k, out, alive, (k > LAT));
         end
      end
   endtask

   task automatic test_glitch;
      do_reset();
      repeat (3) period(3, 20);
      checks++;
      if (ep_cnt != GLITCH_EP || tog_cnt != 2 * GLITCH_EP) begin
         errors++;
         $display("FAIL glitch_3clk: edges=%0d toggles=%0d required %0d/%0d", ep_cnt, tog_cnt, GLITCH_EP, 2 * GLITCH_EP);
      end
      ep_cnt = 0;
      repeat (3) period(4, 20);
      checks++;
      if (ep_cnt != 3 || out !== 1'b0) begin
         errors++;
         $display("FAIL glitch_4clk: edges=%0d out=%b required 3/0", ep_cnt, out);
      end
   endtask

   task automatic test_div10;
      do_reset();
      range = 2'b01;
      repeat (3) tick();
      tog_cnt = 0;
      for (int p = 1; p <= 25; p++) begin
         period(20, 20);
         checks++;
         if (out !== 1'((p / 5) % 2)) begin
            errors++;
            $display("FAIL div10 period %0d: out=%b required %b", p, out, 1'((p / 5) % 2));
         end
      end
      checks++;
      if (tog_cnt != 5 || out !== 1'b1) begin
         errors++;
         $display("FAIL div10_total: toggles=%0d out=%b required 5/1", tog_cnt, out);
      end
   endtask

   task automatic test_div100;
      do_reset();
      range = 2'b10;
      repeat (3) tick();
      tog_cnt = 0;
      for (int p = 1; p <= 100; p++) begin
         period(20, 20);
         if (p == 49 || p == 50 || p == 99 || p == 100) begin
            checks++;
            if (out !== 1'((p / 50) % 2)) begin
               errors++;
               $display("FAIL div100 period %0d: out=%b required %b", p, out, 1'((p / 50) % 2));
            end
         end
      end
      checks++;
      if (tog_cnt != 2) begin
         errors++;
         $display("FAIL div100_toggles: toggles=%0d required 2", tog_cnt);
      end
   endtask

   task automatic test_range_switch;
      do_reset();
      range = 2'b01;
      repeat (3) tick();
      repeat (7) period(20, 20);
      checks++;
      if (out !== 1'b1) begin
         errors++;
         $display("FAIL switch_pre: out=%b required 1", out);
      end
      sig_in = 1'b1;
      wait_edge();
      range = 2'b10;
      tick();
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL switch_clear: out=%b required 0", out);
      end
      repeat (13) tick();
      sig_in = 1'b0;
      repeat (20) tick();
      repeat (49) period(20, 20);
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL switch_49: out=%b required 0", out);
      end
      period(20, 20);
      checks++;
      if (out !== 1'b1) begin
         errors++;
         $display("FAIL switch_50: out=%b required 1", out);
      end
   endtask

   task automatic test_alive;
      do_reset();
      sig_in = 1'b1;
      wait_edge();
      tick();
      checks++;
      if (alive !== 1'b1) begin
         errors++;
         $display("FAIL alive_rise: alive=%b required 1", alive);
      end
      repeat (TIMEOUT - 1) tick();
      checks++;
      if (alive !== 1'b1) begin
         errors++;
         $display("FAIL alive_hold: alive=%b required 1", alive);
      end
      tick();
      checks++;
      if (alive !== 1'b0) begin
         errors++;
         $display("FAIL alive_fall: alive=%b required 0", alive);
      end
      sig_in = 1'b0;
      repeat (10) tick();
      sig_in = 1'b1;
      wait_edge();
      repeat (50) tick();
      checks++;
      if (alive !== 1'b1 || out !== 1'b1) begin
         errors++;
         $display("FAIL alive_pre_reset: alive=%b out=%b required 1/1", alive, out);
      end
      rst = 1'b1;
      #2;
      checks++;
      if (alive !== 1'b0 || out !== 1'b0 || edge_pulse !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: alive=%b out=%b edge_pulse=%b required 0/0/0", alive, out, edge_pulse);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_div10();
      test_div100();
      test_range_switch();
      test_alive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
